i2c_slave: RTL and testbench
============================

Name: i2c_slave

Overview:
- I2C target (responder) that is the far end of the team's I2C master.
- Used in benches as a DAC stand-in, and on-chip for configuration by an external host.
- Detects START/STOP, matches a 7-bit address, ACKs, and delivers write bytes as single-cycle strobes.
- Serves read bytes from a parallel input; drives SDA open-drain style through sda_out (1 = released).

Parameters:
- SLAVE_ADDR, 7'h4C, 7-bit address this target responds to.
- SYNC_STAGES, 2, flip-flop synchronizer depth on scl and sda_in (min 2).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- scl  input  1  I2C clock from bus (asynchronous)
- sda_in  input  1  SDA level from pad (asynchronous)
- sda_out  output  1  0 = pull SDA low, 1 = release
- rx_data  output  8  last byte written by master
- rx_valid  output  1  one-cycle strobe; rx_data valid
- tx_data  input  8  byte to return on reads; sampled on tx_req cycle
- tx_req  output  1  one-cycle strobe requesting tx_data for next read byte
- busy  output  1  high between addressed START and STOP/NACK
- start_det  output  1  one-cycle strobe on START or repeated START
- stop_det  output  1  one-cycle strobe on STOP

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: sda_out=1, rx_data=0, rx_valid=0, tx_req=0, busy=0, start_det=0, stop_det=0, state=IDLE, bit counter=0.
- Input synchronization: scl and sda_in pass through SYNC_STAGES FFs, then one history FF for edge detection.
  - scl_rise / scl_fall are single-cycle pulses on synchronized edges.
- START: synchronized SDA falls while SCL high.
  - Pulse start_det; enter ADDR; clear bit counter.
  - Valid from any state, so a repeated START aborts the current byte.
- STOP: synchronized SDA rises while SCL high.
  - Pulse stop_det; release sda_out; go to IDLE; busy=0.
- Sampling and driving: bits are sampled MSB-first on scl_rise; sda_out changes only on scl_fall.
- ADDR: shift 8 bits (7 address + R/W).
  - On the 8th scl_rise, compare against SLAVE_ADDR.
  - Match: at the next scl_fall drive sda_out=0 (ACK), set busy=1, enter ADDR_ACK.
  - Mismatch: keep sda_out=1 and go to IGNORE until START/STOP.
- ADDR_ACK: at the next scl_fall (end of ACK clock), branch on R/W.
  - R/W=0: release SDA and enter WRITE.
  - R/W=1: enter READ.
- tx_req timing for reads: tx_req pulses on the scl_fall that ends ADDR_ACK or READ_ACK, in the same cycle as the transition.
  - tx_data is captured combinationally in that cycle into the shift register.
  - Bit 7 is driven on sda_out in that same scl_fall.
- WRITE: shift 8 bits.
  - On the 8th scl_rise: rx_data <= shifted byte and rx_valid=1 for exactly one clk (latency: 1 clk after synchronized scl_rise).
  - Next scl_fall: ACK (sda_out=0), enter WRITE_ACK.
  - The following scl_fall releases SDA and returns to WRITE.
  - Bytes are unlimited; the counter wraps 7→0 per byte.
- READ: drive the next bit on each scl_fall. After bit 0's clock (8th scl_fall), release SDA and enter READ_ACK.
- READ_ACK: sample SDA on scl_rise.
  - 0 (ACK): continue READ with tx_req at the next scl_fall.
  - 1 (NACK): go to IGNORE with SDA released and busy=0.
- Simultaneous events: STOP/START detection has priority over scl edge processing in the same cycle.
- Mid-operation reset: rst asserted mid-byte releases SDA immediately (next clk), discards the partial byte, no rx_valid.
- General call address 0x00 is not supported: it is treated as a mismatch.

Optional Feature:
- Macro: I2C_SLAVE_GLITCH_FILTER_EN.
- Defined: after the synchronizer, each line must hold the same value for 3 consecutive clk samples before the filtered level updates.
  - Pulses of 1–2 clk are rejected.
  - All edge, START and STOP detection uses filtered levels; latency grows by 2 clk.
- Undefined: filtered level equals the synchronized level; no extra latency.

Test Plan:
- Write address 0x4C+W, data 0xA5, 0x3C, STOP → ACK on all 3 bytes; rx_valid pulses twice with rx_data=0xA5 then 0x3C; stop_det once; busy low after STOP.
- Address 0x4D+W → SDA never pulled low; no rx_valid or tx_req; busy stays 0; STOP returns to IDLE.
- Read 0x4C+R with tx_data=0x96 then 0x5A, master ACKs the first and NACKs the second → bus bits 10010110, 01011010; tx_req pulses twice; SDA released after NACK.
- Write 0x4C+W, 4 bits of data, repeated START, 0x4C+R → no rx_valid for the partial byte; start_det twice; read proceeds normally.
- rst asserted for 1 clk while driving ACK → sda_out=1 the next clk; state IDLE; the following full transaction works.
- With I2C_SLAVE_GLITCH_FILTER_EN: 1-clk low pulse on SDA while SCL high → no start_det. Without the macro the same pulse → start_det=1.

Source files
------------

// File: rtl/i2c_slave.sv
// I2C target: START/STOP detection, 7-bit address match, byte-wide write strobes and read service.
// Optional macro I2C_SLAVE_GLITCH_FILTER_EN adds a 3-sample glitch filter after the synchronizers.
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h4C,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_out,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy,
    output logic       start_det,
    output logic       stop_det
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WRITE, S_WRITE_ACK, S_READ, S_READ_ACK, S_IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_r, sda_sync_r;
    logic scl_s_s, sda_s_s, scl_f_s, sda_f_s, scl_d_r, sda_d_r;
    logic scl_rise_s, scl_fall_s, start_s, stop_s, addr_match_s;
    logic [7:0] byte_s;

    state_t     state_r, state_n;
    logic [7:0] shift_r, shift_n;
    logic [2:0] cnt_r, cnt_n;
    logic       byte_done_r, byte_done_n, rw_r, rw_n;
    logic       sda_out_r, sda_n, busy_r, busy_n;
    logic [7:0] rx_data_r, rx_data_n;
    logic       rx_valid_r, rx_valid_n, tx_req_r, tx_req_n;
    logic       start_det_r, start_n, stop_det_r, stop_n;

    // Synchronizer chains for the asynchronous bus lines (idle bus level is high)
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_r <= {SYNC_STAGES{1'b1}};
            sda_sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl};
            sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda_in};
        end
    end

    assign scl_s_s = scl_sync_r[SYNC_STAGES-1];
    assign sda_s_s = sda_sync_r[SYNC_STAGES-1];

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [1:0] scl_hist_r, sda_hist_r;
    logic       scl_filt_r, sda_filt_r;

    // Filtered level follows the line only after three equal consecutive samples
    always_comb begin
        scl_f_s = scl_filt_r;
        sda_f_s = sda_filt_r;
        if ((scl_s_s == scl_hist_r[0]) && (scl_hist_r[0] == scl_hist_r[1])) begin
            scl_f_s = scl_s_s;
        end else begin
            scl_f_s = scl_filt_r;
        end
        if ((sda_s_s == sda_hist_r[0]) && (sda_hist_r[0] == sda_hist_r[1])) begin
            sda_f_s = sda_s_s;
        end else begin
            sda_f_s = sda_filt_r;
        end
    end

    // Sample history and held filtered level
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_hist_r <= 2'b11;
            sda_hist_r <= 2'b11;
            scl_filt_r <= 1'b1;
            sda_filt_r <= 1'b1;
        end else begin
            scl_hist_r <= {scl_hist_r[0], scl_s_s};
            sda_hist_r <= {sda_hist_r[0], sda_s_s};
            scl_filt_r <= scl_f_s;
            sda_filt_r <= sda_f_s;
        end
    end
`else
    assign scl_f_s = scl_s_s;
    assign sda_f_s = sda_s_s;
`endif

    // One-sample history of the filtered levels for edge and condition detection
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_d_r <= 1'b1;
            sda_d_r <= 1'b1;
        end else begin
            scl_d_r <= scl_f_s;
            sda_d_r <= sda_f_s;
        end
    end

    assign scl_rise_s   = scl_f_s & ~scl_d_r;
    assign scl_fall_s   = ~scl_f_s & scl_d_r;
    assign start_s      = scl_f_s & scl_d_r & sda_d_r & ~sda_f_s;
    assign stop_s       = scl_f_s & scl_d_r & ~sda_d_r & sda_f_s;
    assign byte_s       = {shift_r[6:0], sda_f_s};
    // General call (address 0) is never acknowledged
    assign addr_match_s = (byte_s[7:1] == SLAVE_ADDR) && (byte_s[7:1] != 7'h00);

    // Next-state and datapath decode; bus conditions take priority over clock edges
    always_comb begin
        state_n     = state_r;
        shift_n     = shift_r;
        cnt_n       = cnt_r;
        byte_done_n = byte_done_r;
        rw_n        = rw_r;
        sda_n       = sda_out_r;
        busy_n      = busy_r;
        rx_data_n   = rx_data_r;
        rx_valid_n  = 1'b0;
        tx_req_n    = 1'b0;
        start_n     = 1'b0;
        stop_n      = 1'b0;
        if (start_s) begin
            start_n     = 1'b1;
            state_n     = S_ADDR;
            cnt_n       = 3'd0;
            byte_done_n = 1'b0;
            sda_n       = 1'b1;
        end else if (stop_s) begin
            stop_n      = 1'b1;
            state_n     = S_IDLE;
            cnt_n       = 3'd0;
            byte_done_n = 1'b0;
            sda_n       = 1'b1;
            busy_n      = 1'b0;
        end else begin
            case (state_r)
                S_ADDR: begin
                    if (scl_rise_s) begin
                        shift_n = byte_s;
                        if (cnt_r == 3'd7) begin
                            cnt_n = 3'd0;
                            if (addr_match_s) begin
                                byte_done_n = 1'b1;
                                rw_n        = byte_s[0];
                            end else begin
                                state_n = S_IGNORE;
                                busy_n  = 1'b0;
                            end
                        end else begin
                            cnt_n = cnt_r + 3'd1;
                        end
                    end else if (scl_fall_s && byte_done_r) begin
                        byte_done_n = 1'b0;
                        sda_n       = 1'b0;
                        busy_n      = 1'b1;
                        state_n     = S_ADDR_ACK;
                    end else begin
                        state_n = state_r;
                    end
                end
                S_ADDR_ACK, S_READ_ACK: begin
                    if (scl_rise_s && (state_r == S_READ_ACK) && sda_f_s) begin
                        state_n = S_IGNORE;
                        busy_n  = 1'b0;
                        sda_n   = 1'b1;
                    end else if (scl_fall_s && (state_r == S_ADDR_ACK) && !rw_r) begin
                        sda_n   = 1'b1;
                        cnt_n   = 3'd0;
                        state_n = S_WRITE;
                    end else if (scl_fall_s) begin
                        // Load the next read byte and put its MSB on the bus in the same cycle
                        tx_req_n = 1'b1;
                        shift_n  = tx_data;
                        sda_n    = tx_data[7];
                        cnt_n    = 3'd0;
                        state_n  = S_READ;
                    end else begin
                        state_n = state_r;
                    end
                end
                S_WRITE: begin
                    if (scl_rise_s) begin
                        shift_n = byte_s;
                        if (cnt_r == 3'd7) begin
                            cnt_n       = 3'd0;
                            rx_data_n   = byte_s;
                            rx_valid_n  = 1'b1;
                            byte_done_n = 1'b1;
                        end else begin
                            cnt_n = cnt_r + 3'd1;
                        end
                    end else if (scl_fall_s && byte_done_r) begin
                        byte_done_n = 1'b0;
                        sda_n       = 1'b0;
                        state_n     = S_WRITE_ACK;
                    end else begin
                        state_n = state_r;
                    end
                end
                S_WRITE_ACK: begin
                    if (scl_fall_s) begin
                        sda_n   = 1'b1;
                        state_n = S_WRITE;
                    end else begin
                        state_n = state_r;
                    end
                end
                S_READ: begin
                    if (scl_fall_s && (cnt_r == 3'd7)) begin
                        sda_n   = 1'b1;
                        cnt_n   = 3'd0;
                        state_n = S_READ_ACK;
                    end else if (scl_fall_s) begin
                        sda_n   = shift_r[6];
                        shift_n = {shift_r[6:0], 1'b0};
                        cnt_n   = cnt_r + 3'd1;
                    end else begin
                        state_n = state_r;
                    end
                end
                S_IDLE, S_IGNORE: begin
                    state_n = state_r;
                end
                default: begin
                    state_n = S_IDLE;
                    sda_n   = 1'b1;
                    busy_n  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            shift_r     <= 8'h00;
            cnt_r       <= 3'd0;
            byte_done_r <= 1'b0;
            rw_r        <= 1'b0;
            sda_out_r   <= 1'b1;
            busy_r      <= 1'b0;
            rx_data_r   <= 8'h00;
            rx_valid_r  <= 1'b0;
            tx_req_r    <= 1'b0;
            start_det_r <= 1'b0;
            stop_det_r  <= 1'b0;
        end else begin
            state_r     <= state_n;
            shift_r     <= shift_n;
            cnt_r       <= cnt_n;
            byte_done_r <= byte_done_n;
            rw_r        <= rw_n;
            sda_out_r   <= sda_n;
            busy_r      <= busy_n;
            rx_data_r   <= rx_data_n;
            rx_valid_r  <= rx_valid_n;
            tx_req_r    <= tx_req_n;
            start_det_r <= start_n;
            stop_det_r  <= stop_n;
        end
    end

    assign sda_out   = sda_out_r;
    assign busy      = busy_r;
    assign rx_data   = rx_data_r;
    assign rx_valid  = rx_valid_r;
    assign tx_req    = tx_req_r;
    assign start_det = start_det_r;
    assign stop_det  = stop_det_r;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged I2C master, transaction table with a reference model, directed corner cases.
module tb_i2c_slave;

    localparam logic [6:0] ADDR = 7'h4C;
    localparam int Q = 8;

    logic       clk, rst, scl, m_sda, sda_out, rx_valid, tx_req, busy, start_det, stop_det;
    logic       sda_line;
    logic [7:0] rx_data, tx_data;

    int total = 0;
    int bad = 0;
    int tx_cnt = 0, start_cnt = 0, stop_cnt = 0, low_cnt = 0;
    logic [7:0] rx_q [$];

    assign sda_line = m_sda & sda_out;

    i2c_slave #(.SLAVE_ADDR(ADDR), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .scl(scl), .sda_in(sda_line), .sda_out(sda_out),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_req(tx_req),
        .busy(busy), .start_det(start_det), .stop_det(stop_det)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event monitor sampled away from the active edge
    always @(negedge clk) begin
        if (rx_valid) rx_q.push_back(rx_data);
        if (tx_req) tx_cnt++;
        if (start_det) start_cnt++;
        if (stop_det) stop_cnt++;
        if (!sda_out) low_cnt++;
    end

    typedef struct {
        logic [6:0] addr;
        logic       rw;
        int         n;
        logic [7:0] d [4];
        logic       exp_ack;
        int         exp_rx;
        int         exp_tx;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Reference rules: acknowledged only for our address, never for general call
    function automatic vec_t model(input vec_t v);
        vec_t r;
        r = v;
        r.exp_ack = (v.addr == ADDR) && (v.addr != 7'h00);
        r.exp_rx  = (r.exp_ack && !v.rw) ? v.n : 0;
        r.exp_tx  = (r.exp_ack && v.rw) ? v.n : 0;
        return r;
    endfunction

    task automatic qd();
        repeat (Q) @(posedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; qd(); scl = 1'b1; qd(); m_sda = 1'b0; qd(); scl = 1'b0; qd();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; qd(); scl = 1'b1; qd(); m_sda = 1'b1; qd();
    endtask

    task automatic write_bit(input logic b);
        m_sda = b; qd(); scl = 1'b1; qd(); qd(); scl = 1'b0; qd();
    endtask

    task automatic read_bit(output logic b);
        m_sda = 1'b1; qd(); scl = 1'b1; qd(); b = sda_line; qd(); scl = 1'b0; qd();
    endtask

    task automatic send_byte(input logic [7:0] v, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) write_bit(v[i]);
        read_bit(b);
        ack = ~b;
    endtask

    task automatic recv_byte(input logic [7:0] next_tx, input logic ack, output logic [7:0] v);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            v[i] = b;
        end
        tx_data = next_tx;
        write_bit(~ack);
    endtask

    task automatic run_vec(input vec_t v);
        int tx0, st0, sp0, lo0;
        logic ack;
        logic [7:0] b;
        rx_q.delete();
        tx0 = tx_cnt; st0 = start_cnt; sp0 = stop_cnt; lo0 = low_cnt;
        tx_data = v.d[0];
        i2c_start();
        send_byte({v.addr, v.rw}, ack);
        check("addr_ack", ack, v.exp_ack);
        @(negedge clk);
        check("busy_in_txn", busy, v.exp_ack);
        for (int i = 0; i < v.n; i++) begin
            if (v.exp_ack && v.rw) begin
                recv_byte((i + 1 < v.n) ? v.d[i + 1] : 8'h00, (i + 1 < v.n), b);
                check("read_byte", b, v.d[i]);
            end else begin
                send_byte(v.d[i], ack);
                check("data_ack", ack, v.exp_ack);
            end
        end
        i2c_stop();
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("rx_count", rx_q.size(), v.exp_rx);
        for (int i = 0; i < v.exp_rx && i < rx_q.size(); i++) check("rx_data", rx_q[i], v.d[i]);
        check("tx_req_count", tx_cnt - tx0, v.exp_tx);
        check("start_count", start_cnt - st0, 1);
        check("stop_count", stop_cnt - sp0, 1);
        check("busy_after", busy, 1'b0);
        check("sda_released", sda_out, 1'b1);
        if (!v.exp_ack) check("no_sda_drive", low_cnt - lo0, 0);
    endtask

    initial begin
        logic ack;
        logic [7:0] b;
        int k, st0, tx0;

        // Directed rows with hand-derived expectations, then random rows through the model
        vecs[0] = '{addr: 7'h4C, rw: 1'b0, n: 2, d: '{8'hA5, 8'h3C, 8'h00, 8'h00}, exp_ack: 1'b1, exp_rx: 2, exp_tx: 0};
        vecs[1] = '{addr: 7'h4D, rw: 1'b0, n: 1, d: '{8'h11, 8'h00, 8'h00, 8'h00}, exp_ack: 1'b0, exp_rx: 0, exp_tx: 0};
        vecs[2] = '{addr: 7'h4C, rw: 1'b1, n: 2, d: '{8'h96, 8'h5A, 8'h00, 8'h00}, exp_ack: 1'b1, exp_rx: 0, exp_tx: 2};
        vecs[3] = '{addr: 7'h00, rw: 1'b0, n: 1, d: '{8'h77, 8'h00, 8'h00, 8'h00}, exp_ack: 1'b0, exp_rx: 0, exp_tx: 0};
        for (int i = 4; i < 12; i++) begin
            vecs[i].addr = ($urandom_range(0, 2) != 0) ? ADDR : 7'($urandom);
            vecs[i].rw   = 1'($urandom);
            vecs[i].n    = $urandom_range(1, 4);
            for (int j = 0; j < 4; j++) vecs[i].d[j] = 8'($urandom);
            vecs[i] = model(vecs[i]);
        end

        rst = 1'b1; scl = 1'b1; m_sda = 1'b1; tx_data = 8'h00;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_sda_out", sda_out, 1'b1);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_strobes", {rx_valid, tx_req, start_det, stop_det}, 4'h0);
        check("rst_busy", busy, 1'b0);

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // Partial write byte aborted by repeated START, then a read
        rx_q.delete();
        st0 = start_cnt; tx0 = tx_cnt;
        tx_data = 8'h96;
        i2c_start();
        send_byte({ADDR, 1'b0}, ack);
        check("rs_addr_w_ack", ack, 1'b1);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
        i2c_start();
        send_byte({ADDR, 1'b1}, ack);
        check("rs_addr_r_ack", ack, 1'b1);
        recv_byte(8'h00, 1'b0, b);
        check("rs_read_byte", b, 8'h96);
        i2c_stop();
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("rs_no_rx", rx_q.size(), 0);
        check("rs_start_count", start_cnt - st0, 2);
        check("rs_tx_req", tx_cnt - tx0, 1);

        // Reset pulse while the address ACK is being driven
        i2c_start();
        for (int i = 7; i >= 0; i--) write_bit(8'h98 >> i);
        m_sda = 1'b1;
        k = 0;
        while (sda_out !== 1'b0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("ack_driven", sda_out, 1'b0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_sda", sda_out, 1'b1);
        check("rst_mid_busy", busy, 1'b0);
        qd(); scl = 1'b1; qd(); scl = 1'b0; qd();
        i2c_stop();
        repeat (10) @(posedge clk);
        run_vec(vecs[0]);

        // Single-clock SDA low pulse while SCL is high
        st0 = start_cnt;
        @(posedge clk); #1 m_sda = 1'b0;
        @(posedge clk); #1 m_sda = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
        check("glitch_start", start_cnt - st0, 0);
`else
        check("glitch_start", start_cnt - st0, 1);
`endif
        check("glitch_busy", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
